// File: rtl/mem_bus_pkg.sv
// Shared types and beat-count helpers for the memory bus controller.
package mem_bus_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;

  function automatic int calc_ab(input int pa);
    return (pa + 7) / 8;
  endfunction

  function automatic int calc_db(input int rv);
    return rv / 8;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// Arbitrates fetch/data requests behind the MMU, reports MMU faults and runs
// one word transfer per request on a byte-wide multiplexed address/data bus.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int RV = 16,
  parameter int PA = RV,
  parameter int AB = calc_ab(PA),
  parameter int DB = calc_db(RV)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ins_req,
  input  logic                 data_read,
  input  logic                 data_write,
  input  logic [PA-RV/16-1:0]  pcp,
  input  logic [PA-RV/16-1:0]  addrp,
  input  logic [RV-1:0]        wdata,
  output logic                 is_pc,
  output logic                 is_read,
  output logic                 is_write,
  input  logic                 mmu_miss_fault,
  input  logic                 mmu_prot_fault,
  output logic                 mmu_fault,
  output logic                 ins_done,
  output logic                 ins_fault,
  output logic                 data_done,
  output logic                 data_fault,
  output logic [RV-1:0]        rdata,
  output logic [7:0]           bus_out,
  input  logic [7:0]           bus_in,
  output logic                 bus_ale,
  output logic                 bus_rd,
  output logic                 bus_wr,
  input  logic                 bus_ready
);

  localparam int ABW = AB * 8;
  localparam int WA  = PA - RV / 16;
  localparam int MB  = (AB > DB) ? AB : DB;
  localparam int BW  = (MB > 1) ? $clog2(MB) : 1;

  state_e          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            ale_q, ale_d, rd_q, rd_d, wr_q, wr_d;
  logic [7:0]      bout_q, bout_d;
  logic            idone_q, idone_d, ifault_q, ifault_d;
  logic            ddone_q, ddone_d, dfault_q, dfault_d;
  logic [RV-1:0]   rdata_q, rdata_d;
  logic [ABW-1:0]  areg_q, areg_d;
  logic [RV-1:0]   wreg_q, wreg_d, rbuf_q, rbuf_d;
  logic            dirw_q, dirw_d, src_ins_q, src_ins_d;
  logic            gnt_ins, gnt_data, fault_w;
  logic [WA-1:0]   req_addr;
  logic [ABW-1:0]  byte_addr;

  // No grant in the cycle a fault pulse is out: the requester is still
  // holding the request it is about to drop.
  always_comb begin
    gnt_ins  = 1'b0;
    gnt_data = 1'b0;
    if (state_q == IDLE && !ifault_q && !dfault_q) begin
      if (data_read || data_write) gnt_data = 1'b1;
      else if (ins_req)            gnt_ins  = 1'b1;
    end
  end

  assign fault_w   = mmu_miss_fault | mmu_prot_fault;
  assign is_pc     = gnt_ins;
  assign is_read   = gnt_data & data_read;
  assign is_write  = gnt_data & data_write;
  assign mmu_fault = (gnt_ins | gnt_data) & fault_w & ~reset;
  assign req_addr  = gnt_data ? addrp : pcp;
  assign byte_addr = ABW'(req_addr) << (RV / 16);

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    ale_d     = 1'b0;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    bout_d    = 8'h00;
    idone_d   = 1'b0;
    ifault_d  = 1'b0;
    ddone_d   = 1'b0;
    dfault_d  = 1'b0;
    rdata_d   = rdata_q;
    areg_d    = areg_q;
    wreg_d    = wreg_q;
    rbuf_d    = rbuf_q;
    dirw_d    = dirw_q;
    src_ins_d = src_ins_q;
    case (state_q)
      IDLE: begin
        if (gnt_ins || gnt_data) begin
          if (fault_w) begin
            ifault_d = gnt_ins;
            dfault_d = gnt_data;
          end else begin
            bout_d    = byte_addr[ABW-1 -: 8];
            areg_d    = byte_addr << 8;
            wreg_d    = wdata;
            rbuf_d    = '0;
            dirw_d    = gnt_data & data_write;
            src_ins_d = gnt_ins;
            beat_d    = '0;
            ale_d     = 1'b1;
            state_d   = ADDR;
          end
        end
      end
      ADDR: begin
        if (beat_q == BW'(AB - 1)) begin
          state_d = DATA;
          beat_d  = '0;
          rd_d    = ~dirw_q;
          wr_d    = dirw_q;
          if (dirw_q) begin
            bout_d = wreg_q[7:0];
            wreg_d = wreg_q >> 8;
          end
        end else begin
          beat_d = beat_q + BW'(1);
          ale_d  = 1'b1;
          bout_d = areg_q[ABW-1 -: 8];
          areg_d = areg_q << 8;
        end
      end
      DATA: begin
        rd_d   = rd_q;
        wr_d   = wr_q;
        bout_d = bout_q;
        if (bus_ready) begin
          if (!dirw_q) rbuf_d[int'(beat_q)*8 +: 8] = bus_in;
          if (beat_q == BW'(DB - 1)) begin
            state_d = DONE;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            bout_d  = 8'h00;
            idone_d = src_ins_q;
            ddone_d = ~src_ins_q;
            if (!dirw_q) rdata_d = rbuf_d;
          end else begin
            beat_d = beat_q + BW'(1);
            if (dirw_q) begin
              bout_d = wreg_q[7:0];
              wreg_d = wreg_q >> 8;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      ale_q    <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      bout_q   <= 8'h00;
      idone_q  <= 1'b0;
      ifault_q <= 1'b0;
      ddone_q  <= 1'b0;
      dfault_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      ale_q    <= ale_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      bout_q   <= bout_d;
      idone_q  <= idone_d;
      ifault_q <= ifault_d;
      ddone_q  <= ddone_d;
      dfault_q <= dfault_d;
      rdata_q  <= rdata_d;
    end
  end

  // Transfer datapath: always reloaded at acceptance, so it needs no reset.
  always_ff @(posedge clk) begin
    areg_q    <= areg_d;
    wreg_q    <= wreg_d;
    rbuf_q    <= rbuf_d;
    dirw_q    <= dirw_d;
    src_ins_q <= src_ins_d;
  end

  assign bus_ale    = ale_q;
  assign bus_rd     = rd_q;
  assign bus_wr     = wr_q;
  assign bus_out    = bout_q;
  assign ins_done   = idone_q;
  assign ins_fault  = ifault_q;
  assign data_done  = ddone_q;
  assign data_fault = dfault_q;
  assign rdata      = rdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl with RV=PA=16 and a simple bus device model.
module tb_mem_bus_ctrl;

  localparam int RV = 16;
  localparam int PA = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          ins_req, data_read, data_write;
  logic [14:0]   pcp, addrp;
  logic [15:0]   wdata;
  logic          is_pc, is_read, is_write;
  logic          mmu_miss_fault, mmu_prot_fault, mmu_fault;
  logic          ins_done, ins_fault, data_done, data_fault;
  logic [15:0]   rdata;
  logic [7:0]    bus_out, bus_in;
  logic          bus_ale, bus_rd, bus_wr, bus_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  exp_bytes[$];
  logic [15:0] exp_rdata_q[$];
  logic [15:0] model_rdata = 16'h0000;

  mem_bus_ctrl #(.RV(RV), .PA(PA)) dut (
    .clk(clk), .reset(reset),
    .ins_req(ins_req), .data_read(data_read), .data_write(data_write),
    .pcp(pcp), .addrp(addrp), .wdata(wdata),
    .is_pc(is_pc), .is_read(is_read), .is_write(is_write),
    .mmu_miss_fault(mmu_miss_fault), .mmu_prot_fault(mmu_prot_fault),
    .mmu_fault(mmu_fault),
    .ins_done(ins_done), .ins_fault(ins_fault),
    .data_done(data_done), .data_fault(data_fault),
    .rdata(rdata), .bus_out(bus_out), .bus_in(bus_in),
    .bus_ale(bus_ale), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clean transaction; the bench acts as the bus device.
  task automatic run_txn(input bit fetch, input bit wr, input bit also_ins,
                         input logic [14:0] wa, input logic [15:0] wd,
                         input logic [15:0] rv, input int stall);
    int cyc, dbeat, stall_left;
    bit done_seen;
    logic [15:0] ba, tmp;
    ba = {wa, 1'b0};
    exp_bytes.push_back(ba[15:8]);
    exp_bytes.push_back(ba[7:0]);
    if (wr) begin
      exp_bytes.push_back(wd[7:0]);
      exp_bytes.push_back(wd[15:8]);
    end else begin
      model_rdata = rv;
    end
    exp_rdata_q.push_back(model_rdata);
    @(posedge clk); #1;
    if (fetch) begin
      pcp = wa; ins_req = 1'b1;
    end else begin
      addrp = wa; wdata = wd; data_read = ~wr; data_write = wr;
      if (also_ins) ins_req = 1'b1;
    end
    @(negedge clk);
    check_val("grant_is_pc", is_pc, fetch);
    check_val("grant_is_read", is_read, !fetch && !wr);
    check_val("grant_is_write", is_write, !fetch && wr);
    check_val("accept_no_mmu_fault", mmu_fault, 0);
    cyc = 0; dbeat = 0; stall_left = stall; done_seen = 0;
    while (!done_seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      bus_ready = 1'b0;
      bus_in = 8'h00;
      if (bus_rd || bus_wr) begin
        if (dbeat == 0 && stall_left > 0) stall_left--;
        else begin
          bus_ready = 1'b1;
          tmp = rv >> (8 * dbeat);
          bus_in = tmp[7:0];
        end
      end
      @(negedge clk);
      if (bus_ale) begin
        if (exp_bytes.size() == 0) check_val("extra_ale", 1, 0);
        else check_val("addr_byte", bus_out, exp_bytes.pop_front());
      end
      if ((bus_rd || bus_wr) && bus_ready) begin
        if (dbeat == 0) check_val("data_dir_wr", bus_wr, wr);
        if (bus_wr) begin
          if (exp_bytes.size() == 0) check_val("extra_wr_beat", 1, 0);
          else check_val("wr_byte", bus_out, exp_bytes.pop_front());
        end
        dbeat++;
      end
      if (ins_fault || data_fault || mmu_fault) check_val("spurious_fault", 1, 0);
      if (ins_done || data_done) begin
        done_seen = 1;
        check_val("done_is_fetch", ins_done, fetch);
        check_val("done_is_data", data_done, !fetch);
        check_val("done_cycle", cyc, 5 + stall);
        check_val("rdata", rdata, exp_rdata_q.pop_front());
        if (fetch) ins_req = 1'b0;
        else begin
          data_read = 1'b0; data_write = 1'b0;
        end
      end
    end
    if (!done_seen) check_val("done_timeout", 0, 1);
    check_val("bytes_left", exp_bytes.size(), 0);
    exp_bytes.delete();
  endtask

  // Faulting request: strobe now, fault pulse next cycle, no bus activity.
  task automatic fault_txn(input bit fetch, input bit miss);
    bit busact;
    busact = 0;
    @(posedge clk); #1;
    if (fetch) begin
      pcp = 15'h0040; ins_req = 1'b1;
    end else begin
      addrp = 15'h0050; wdata = 16'h1111; data_write = 1'b1;
    end
    mmu_miss_fault = miss;
    mmu_prot_fault = ~miss;
    @(negedge clk);
    check_val("flt_mmu_fault_c0", mmu_fault, 1);
    check_val("flt_grant_pc", is_pc, fetch);
    check_val("flt_grant_wr", is_write, !fetch);
    busact |= bus_ale | bus_wr | bus_rd;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("flt_ins_fault_c1", ins_fault, fetch);
    check_val("flt_data_fault_c1", data_fault, !fetch);
    check_val("flt_mmu_fault_c1", mmu_fault, 0);
    check_val("flt_no_regrant", is_pc | is_write, 0);
    busact |= bus_ale | bus_wr | bus_rd;
    ins_req = 1'b0; data_write = 1'b0;
    mmu_miss_fault = 1'b0; mmu_prot_fault = 1'b0;
    check_val("flt_no_bus", busact, 0);
  endtask

  initial begin
    int db;
    bit hit;
    logic [15:0] tmp;
    reset = 1'b1;
    ins_req = 0; data_read = 0; data_write = 0;
    pcp = '0; addrp = '0; wdata = '0;
    mmu_miss_fault = 0; mmu_prot_fault = 0;
    bus_in = '0; bus_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ale", bus_ale, 0);
    check_val("rst_rd_wr", {bus_rd, bus_wr}, 0);
    check_val("rst_bus_out", bus_out, 0);
    check_val("rst_rdata", rdata, 0);
    check_val("rst_pulses", {ins_done, ins_fault, data_done, data_fault, mmu_fault}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset during the second data beat of a read.
    @(posedge clk); #1;
    addrp = 15'h0010; data_read = 1'b1;
    db = 0; hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk); #1;
      bus_ready = 1'b0;
      if (bus_rd) begin
        if (db == 1) begin
          reset = 1'b1; hit = 1;
        end
        bus_ready = 1'b1;
        tmp = 16'h5A3C >> (8 * db);
        bus_in = tmp[7:0];
        db++;
      end
    end
    check_val("rstmid_reached_beat2", hit, 1);
    @(posedge clk); #1;
    reset = 1'b0; data_read = 1'b0; bus_ready = 1'b0;
    @(negedge clk);
    check_val("rstmid_strobes", {bus_ale, bus_rd, bus_wr}, 0);
    check_val("rstmid_rdata", rdata, 0);
    hit = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      hit |= data_done | ins_done | bus_ale | bus_rd;
    end
    check_val("rstmid_quiet", hit, 0);

    // Fetch, no wait states.
    run_txn(1, 0, 0, 15'h1234, 16'h0000, 16'hABCD, 0);
    // Data write with two wait cycles on beat 0.
    run_txn(0, 1, 0, 15'h0080, 16'hBEEF, 16'h0000, 2);
    // Fetch and data read together: data first, fetch right after.
    run_txn(0, 0, 1, 15'h0200, 16'h0000, 16'h1357, 0);
    run_txn(1, 0, 0, 15'h0300, 16'h0000, 16'h2468, 0);
    // Protection fault on a write.
    fault_txn(0, 0);
    hit = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      hit |= bus_ale | bus_wr | data_done;
    end
    check_val("prot_flt_no_bus_after", hit, 0);
    // Miss fault immediately followed by a clean fetch.
    fault_txn(1, 1);
    run_txn(1, 0, 0, 15'h7FFF, 16'h0000, 16'hC0DE, 0);
    // Read with one wait state.
    run_txn(0, 0, 0, 15'h4321, 16'h0000, 16'h9E71, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
